segment_reader: RTL and testbench

- Reads the seven-segment bus produced by the display path (segments A–G plus decimal point P) and recovers the displayed value. This is the receive-side counterpart of the display decoder.
- Synchronises the eight segment lines and accepts a pattern only after it has been stable for a set number of cycles. It then decodes that pattern to a hex digit and flags blank or illegal patterns.
- Used as an on-board self-check of the display driver, and as the input stage when another board's display lines are cabled in.

---
 rtl/segment_reader.sv | 166 ++++++++++++++++
 tb/tb_segment_reader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_reader.sv
// Receive side of the seven-segment display path: synchronises the segment lines,
// waits for a stable pattern and decodes it back to a hex digit.
module segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic       P,
    output logic [3:0] digit,
    output logic       dp,
    output logic       valid,
    output logic       blank,
    output logic       err,
    output logic       update,
    output logic [7:0] change_count
);

    typedef enum logic [1:0] {
        StIdle,
        StSettling,
        StLocked
    } state_e;

    localparam logic [7:0] DarkLine    = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] AcceptCount = 8'(STABLE_CYCLES - 1);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_prev;
    logic [7:0] r_cnt;
    logic [7:0] r_acc;
    state_e     r_state;
    logic [3:0] r_digit;
    logic       r_dp;
    logic       r_valid;
    logic       r_blank;
    logic       r_err;
    logic       r_update;
    logic [7:0] r_changes;

    logic [7:0] w_norm;
    logic       w_same;
    logic       w_accept;
    logic       w_legal;
    logic [3:0] w_dec;

    assign w_norm   = r_sync2 ^ DarkLine;
    assign w_same   = (r_sync2 == r_prev);
    // The count only reaches the threshold after STABLE_CYCLES matching comparisons.
    assign w_accept = w_same && (r_cnt == AcceptCount) && (r_state != StLocked);

    always_comb begin
        w_legal = 1'b1;
        w_dec   = 4'h0;
        case (w_norm[6:0])
            7'h3F:   w_dec = 4'h0;
            7'h06:   w_dec = 4'h1;
            7'h5B:   w_dec = 4'h2;
            7'h4F:   w_dec = 4'h3;
            7'h66:   w_dec = 4'h4;
            7'h6D:   w_dec = 4'h5;
            7'h7D:   w_dec = 4'h6;
            7'h07:   w_dec = 4'h7;
            7'h7F:   w_dec = 4'h8;
            7'h6F:   w_dec = 4'h9;
            7'h77:   w_dec = 4'hA;
            7'h7C:   w_dec = 4'hB;
            7'h39:   w_dec = 4'hC;
            7'h5E:   w_dec = 4'hD;
            7'h79:   w_dec = 4'hE;
            7'h71:   w_dec = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= DarkLine;
            r_sync2   <= DarkLine;
            r_prev    <= DarkLine;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_state   <= StIdle;
            r_digit   <= 4'h0;
            r_dp      <= 1'b0;
            r_valid   <= 1'b0;
            r_blank   <= 1'b1;
            r_err     <= 1'b0;
            r_update  <= 1'b0;
            r_changes <= '0;
        end else begin
            r_sync1  <= {P, G, F, E, D, C, B, A};
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_update <= 1'b0;

            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state <= StLocked;
                    end else if (!w_same) begin
                        r_state <= StSettling;
                    end
                end
                StSettling: begin
                    if (w_accept) begin
                        r_state <= StLocked;
                    end
                end
                StLocked: begin
                    if (!w_same) begin
                        r_state <= StSettling;
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_accept) begin
                r_dp  <= w_norm[7];
                r_acc <= w_norm;
                if (w_norm[6:0] == 7'h00) begin
                    r_blank <= 1'b1;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end else if (w_legal) begin
                    r_digit <= w_dec;
                    r_blank <= 1'b0;
                    r_valid <= 1'b1;
                    r_err   <= 1'b0;
                end else begin
                    r_blank <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
                // Decimal point counts as part of the pattern for change detection.
                if (w_norm != r_acc) begin
                    r_update  <= 1'b1;
                    r_changes <= r_changes + 8'd1;
                end
            end
        end
    end

    assign digit        = r_digit;
    assign dp           = r_dp;
    assign valid        = r_valid;
    assign blank        = r_blank;
    assign err          = r_err;
    assign update       = r_update;
    assign change_count = r_changes;

endmodule

// File: tb/tb_segment_reader.sv
// Bench for segment_reader: directed scenarios plus randomised patterns against a run-length model.
module tb_segment_reader;

    localparam int S0 = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus0  = 8'hFF;
    logic [7:0] bus1  = 8'h00;

    logic [3:0] digit0, digit1;
    logic       dp0, valid0, blank0, err0, update0;
    logic       dp1, valid1, blank1, err1, update1;
    logic [7:0] count0, count1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    localparam logic [16:0] ResetVal = {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    always #5 clk = ~clk;

    segment_reader #(.STABLE_CYCLES(S0), .ACTIVE_LOW(1'b1)) u_dut0 (
        .clk(clk), .reset(reset),
        .A(bus0[0]), .B(bus0[1]), .C(bus0[2]), .D(bus0[3]),
        .E(bus0[4]), .F(bus0[5]), .G(bus0[6]), .P(bus0[7]),
        .digit(digit0), .dp(dp0), .valid(valid0), .blank(blank0), .err(err0),
        .update(update0), .change_count(count0)
    );

    segment_reader #(.STABLE_CYCLES(1), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .reset(reset),
        .A(bus1[0]), .B(bus1[1]), .C(bus1[2]), .D(bus1[3]),
        .E(bus1[4]), .F(bus1[5]), .G(bus1[6]), .P(bus1[7]),
        .digit(digit1), .dp(dp1), .valid(valid1), .blank(blank1), .err(err1),
        .update(update1), .change_count(count1)
    );

    wire [16:0] obs0 = {digit0, dp0, valid0, blank0, err0, update0, count0};
    wire [16:0] obs1 = {digit1, dp1, valid1, blank1, err1, update1, count1};

    // Reference model for the ACTIVE_LOW=1, STABLE_CYCLES=S0 instance: two-sample delay,
    // then a pattern is taken once its run of identical samples reaches S0+1.
    logic [7:0] m_s1, m_s2, m_acc;
    logic [7:0] hist [$];
    int         m_run;
    bit         m_found;
    logic [3:0] exp_digit;
    logic       exp_dp, exp_valid, exp_blank, exp_err, exp_update;
    logic [7:0] exp_count;
    wire [16:0] exp0 = {exp_digit, exp_dp, exp_valid, exp_blank, exp_err, exp_update, exp_count};

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 8'h00;
            m_s2 = 8'h00;
            m_acc = 8'h00;
            hist = '{8'h00};
            exp_digit = 4'h0;
            exp_dp = 1'b0;
            exp_valid = 1'b0;
            exp_blank = 1'b1;
            exp_err = 1'b0;
            exp_update = 1'b0;
            exp_count = 8'h00;
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > S0 + 2) hist.delete(0);
            m_run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != m_s2) break;
                m_run++;
            end
            exp_update = 1'b0;
            if (m_run == S0 + 1) begin
                exp_dp = m_s2[7];
                m_found = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    if (seg_tab[i] == m_s2[6:0]) begin
                        m_found = 1'b1;
                        exp_digit = 4'(i);
                    end
                end
                exp_blank = (m_s2[6:0] == 7'h00);
                exp_valid = m_found;
                exp_err = !m_found && !exp_blank;
                if (m_s2 != m_acc) begin
                    exp_update = 1'b1;
                    exp_count = exp_count + 8'd1;
                    m_acc = m_s2;
                end
            end
            m_s2 = m_s1;
            m_s1 = ~bus0;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus0 = 8'hFF;
        bus1 = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs0 !== ResetVal) $display("FAIL reset_dut0: got %h expected %h", obs0, ResetVal);
        else n_pass++;
        n_checks++;
        if (obs1 !== ResetVal) $display("FAIL reset_dut1: got %h expected %h", obs1, ResetVal);
        else n_pass++;
    endtask

    task automatic test_first_accept();
        reset = 1'b0;
        bus0 = ~8'h4F;
        for (int e = 0; e <= 7; e++) begin
            @(negedge clk);
            if (e == 5) begin
                n_checks++;
                if ({valid0, update0} !== 2'b00)
                    $display("FAIL early_accept: got valid/update %b expected 00", {valid0, update0});
                else n_pass++;
            end
            if (e == 6) begin
                n_checks++;
                if (obs0 !== {4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01})
                    $display("FAIL first_accept: got %h expected %h", obs0,
                             {4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01});
                else n_pass++;
            end
            if (e == 7) begin
                n_checks++;
                if (update0 !== 1'b0) $display("FAIL update_width: got %b expected 0", update0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_glitch();
        repeat (3) @(negedge clk);
        bus0 = ~8'h7F;
        repeat (3) @(negedge clk);
        bus0 = ~8'h4F;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if ({digit0, update0, count0} !== {4'h3, 1'b0, 8'h01})
                $display("FAIL glitch cycle %0d: got %h expected %h", c,
                         {digit0, update0, count0}, {4'h3, 1'b0, 8'h01});
            else n_pass++;
        end
    endtask

    task automatic test_all_digits();
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            bus0 = ~{1'b0, seg_tab[i]};
            repeat (10) begin
                @(negedge clk);
                if (update0) pulses++;
            end
            n_checks++;
            if ({digit0, valid0} !== {4'(i), 1'b1})
                $display("FAIL digit_step %0d: got %h/%b expected %h/1", i, digit0, valid0, 4'(i));
            else n_pass++;
        end
        n_checks++;
        if (pulses != 16 || count0 !== 8'd17)
            $display("FAIL digit_updates: got %0d pulses count %0d expected 16 and 17", pulses, count0);
        else n_pass++;
    endtask

    task automatic test_illegal_blank();
        int pulses = 0;
        bus0 = ~8'h49;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({digit0, valid0, blank0, err0} !== {4'hF, 3'b001})
            $display("FAIL illegal: got %h expected %h", {digit0, valid0, blank0, err0},
                     {4'hF, 3'b001});
        else n_pass++;
        bus0 = 8'hFF;
        repeat (10) begin
            @(negedge clk);
            if (update0) pulses++;
        end
        n_checks++;
        if ({valid0, blank0, err0} !== 3'b010 || pulses != 1 || count0 !== 8'd19)
            $display("FAIL blank: got vbe %b pulses %0d count %0d expected 010, 1, 19",
                     {valid0, blank0, err0}, pulses, count0);
        else n_pass++;
    endtask

    task automatic test_dp();
        int pulses = 0;
        bus0 = ~8'hED;
        repeat (10) begin
            @(negedge clk);
            if (update0) pulses++;
        end
        n_checks++;
        if ({digit0, dp0, valid0} !== {4'h5, 2'b11})
            $display("FAIL dp_lit: got %h expected %h", {digit0, dp0, valid0}, {4'h5, 2'b11});
        else n_pass++;
        bus0 = ~8'h6D;
        repeat (10) begin
            @(negedge clk);
            if (update0) pulses++;
        end
        n_checks++;
        if ({digit0, dp0, valid0} !== {4'h5, 2'b01} || pulses != 2 || count0 !== 8'd21)
            $display("FAIL dp_dark: got %h pulses %0d count %0d expected %h, 2, 21",
                     {digit0, dp0, valid0}, pulses, count0, {4'h5, 2'b01});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus0 = ~8'h07;
        for (int e = 0; e <= 6; e++) @(negedge clk);
        n_checks++;
        if ({digit0, update0, count0} !== {4'h7, 1'b1, 8'd22})
            $display("FAIL pre_reset: got %h expected %h", {digit0, update0, count0},
                     {4'h7, 1'b1, 8'd22});
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs0 !== ResetVal) $display("FAIL mid_reset: got %h expected %h", obs0, ResetVal);
        else n_pass++;
        reset = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            @(negedge clk);
            if (e == 5) begin
                n_checks++;
                if (valid0 !== 1'b0) $display("FAIL reacquire_early: got %b expected 0", valid0);
                else n_pass++;
            end
            if (e == 6) begin
                n_checks++;
                if (obs0 !== {4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01})
                    $display("FAIL reacquire: got %h expected %h", obs0,
                             {4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01});
                else n_pass++;
            end
        end
    endtask

    task automatic test_stable_one();
        int pulses = 0;
        bus1 = 8'h06;
        for (int e = 0; e <= 4; e++) begin
            @(negedge clk);
            if (e == 2) begin
                n_checks++;
                if ({valid1, update1} !== 2'b00)
                    $display("FAIL s1_early: got %b expected 00", {valid1, update1});
                else n_pass++;
            end
            if (e == 3) begin
                n_checks++;
                if ({digit1, valid1, update1, count1} !== {4'h1, 2'b11, 8'h01})
                    $display("FAIL s1_accept: got %h expected %h", {digit1, valid1, update1, count1},
                             {4'h1, 2'b11, 8'h01});
                else n_pass++;
            end
            if (e == 4) begin
                n_checks++;
                if (update1 !== 1'b0) $display("FAIL s1_update_width: got %b expected 0", update1);
                else n_pass++;
            end
        end
        bus1 = 8'h7F;
        @(negedge clk);
        bus1 = 8'h06;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({digit1, update1, count1} !== {4'h1, 1'b0, 8'h01})
                $display("FAIL s1_glitch cycle %0d: got %h expected %h", c,
                         {digit1, update1, count1}, {4'h1, 1'b0, 8'h01});
            else n_pass++;
        end
        bus1 = 8'h5B;
        repeat (2) begin
            @(negedge clk);
            if (update1) pulses++;
        end
        bus1 = 8'h06;
        repeat (8) begin
            @(negedge clk);
            if (update1) pulses++;
        end
        n_checks++;
        if (pulses != 2 || count1 !== 8'd3 || digit1 !== 4'h1)
            $display("FAIL s1_two_cycle: got pulses %0d count %0d digit %h expected 2, 3, 1",
                     pulses, count1, digit1);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] pat;
        int hold = 0;
        int kind;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs0 !== exp0)
                $display("FAIL random_model cycle %0d: got %h expected %h", c, obs0, exp0);
            else n_pass++;
            reset = ($urandom_range(0, 79) == 0);
            if (hold == 0) begin
                kind = $urandom_range(0, 9);
                if (kind < 6) pat = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
                else if (kind == 6) pat = {1'($urandom_range(0, 1)), 7'h00};
                else pat = 8'($urandom);
                hold = $urandom_range(1, 9);
                bus0 = ~pat;
            end
            hold--;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_glitch();
        test_all_digits();
        test_illegal_blank();
        test_dp();
        test_reset_mid();
        test_stable_one();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
